// File: rtl/channels_distributor.sv
// Time-multiplexed per-channel (amplitude, phase) accumulator: sums 2^STADIES samples per channel.
// Optional CHANELS_DISTRIBUTOR_AVERAGE_EN: emit per-channel means (sum >>> STADIES) instead of raw sums.
module channels_distributor #(
  parameter int WIDTH   = 32,
  parameter int CHANELS = 4,
  parameter int STADIES = 2,
  localparam int AW     = (CHANELS > 1) ? $clog2(CHANELS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_vld,
  input  logic [AW-1:0]    i_addres,
  input  logic [WIDTH-1:0] i_ac,
  input  logic [WIDTH-1:0] i_ph,
  output logic             o_vld,
  output logic [AW-1:0]    o_addres,
  output logic [WIDTH-1:0] o_ac,
  output logic [WIDTH-1:0] o_ph
);

  localparam int DEPTH = 1 << AW;
  // With STADIES=0 the counter degenerates to a constant 0 that always equals the last index.
  localparam int CW = (STADIES > 0) ? STADIES : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((1 << STADIES) - 1);
  localparam logic [AW:0]   CH_LIM   = (AW+1)'(CHANELS);

  logic [WIDTH-1:0] r_acc_ac [DEPTH];
  logic [WIDTH-1:0] r_acc_ph [DEPTH];
  logic [CW-1:0]    r_cnt    [DEPTH];

  logic             r_o_vld;
  logic [AW-1:0]    r_o_addres;
  logic [WIDTH-1:0] r_o_ac;
  logic [WIDTH-1:0] r_o_ph;

  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] w_sum_ac;
  logic [WIDTH-1:0] w_sum_ph;
  logic [WIDTH-1:0] w_res_ac;
  logic [WIDTH-1:0] w_res_ph;

  always_comb begin
    w_accept = i_vld && ({1'b0, i_addres} < CH_LIM);
    w_sum_ac = r_acc_ac[i_addres] + i_ac;
    w_sum_ph = r_acc_ph[i_addres] + i_ph;
    w_last   = (r_cnt[i_addres] == CNT_LAST);
`ifdef CHANELS_DISTRIBUTOR_AVERAGE_EN
    w_res_ac = WIDTH'($signed(w_sum_ac) >>> STADIES);
    w_res_ph = WIDTH'($signed(w_sum_ph) >>> STADIES);
`else
    w_res_ac = w_sum_ac;
    w_res_ph = w_sum_ph;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_acc_ac[i] <= '0;
        r_acc_ph[i] <= '0;
        r_cnt[i]    <= '0;
      end
      r_o_vld    <= 1'b0;
      r_o_addres <= '0;
      r_o_ac     <= '0;
      r_o_ph     <= '0;
    end else begin
      r_o_vld <= 1'b0;
      if (w_accept) begin
        if (w_last) begin
          r_o_vld              <= 1'b1;
          r_o_addres           <= i_addres;
          r_o_ac               <= w_res_ac;
          r_o_ph               <= w_res_ph;
          r_acc_ac[i_addres]   <= '0;
          r_acc_ph[i_addres]   <= '0;
          r_cnt[i_addres]      <= '0;
        end else begin
          r_acc_ac[i_addres]   <= w_sum_ac;
          r_acc_ph[i_addres]   <= w_sum_ph;
          r_cnt[i_addres]      <= r_cnt[i_addres] + CW'(1);
        end
      end
    end
  end

  assign o_vld    = r_o_vld;
  assign o_addres = r_o_addres;
  assign o_ac     = r_o_ac;
  assign o_ph     = r_o_ph;

endmodule

// File: tb/tb_channels_distributor.sv
// Scoreboard bench for channels_distributor: a 4-channel and a 3-channel instance share one stimulus stream.
module tb_channels_distributor;

  localparam int W  = 32;
  localparam int ST = 2;
  localparam int N  = 1 << ST;
  localparam int AW = 2;
  localparam int EW = AW + 2 * W;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_vld = 1'b0;
  logic [AW-1:0] i_addres = '0;
  logic [W-1:0]  i_ac = '0;
  logic [W-1:0]  i_ph = '0;

  logic          o_vld0, o_vld1;
  logic [AW-1:0] o_addres0, o_addres1;
  logic [W-1:0]  o_ac0, o_ac1, o_ph0, o_ph1;

  channels_distributor #(.WIDTH(W), .CHANELS(4), .STADIES(ST)) dut0 (
    .clk(clk), .rst(rst), .i_vld(i_vld), .i_addres(i_addres), .i_ac(i_ac), .i_ph(i_ph),
    .o_vld(o_vld0), .o_addres(o_addres0), .o_ac(o_ac0), .o_ph(o_ph0));

  channels_distributor #(.WIDTH(W), .CHANELS(3), .STADIES(ST)) dut1 (
    .clk(clk), .rst(rst), .i_vld(i_vld), .i_addres(i_addres), .i_ac(i_ac), .i_ph(i_ph),
    .o_vld(o_vld1), .o_addres(o_addres1), .o_ac(o_ac1), .o_ph(o_ph1));

  // clock / reset bookkeeping
  always #5 clk = ~clk;

  logic rst_q   = 1'b0;
  logic started = 1'b0;
  always @(posedge clk) begin
    rst_q   <= rst;
    started <= 1'b1;
  end

  // reference model and scoreboard
  logic [EW-1:0] exp_q0[$];
  logic [EW-1:0] exp_q1[$];
  logic [EW-1:0] last_exp[2];
  logic [W-1:0]  m_ac[2][4];
  logic [W-1:0]  m_ph[2][4];
  int            m_n[2][4];
  int            checks = 0;
  int            failures = 0;

  function automatic logic [W-1:0] finish_val(input logic [W-1:0] s);
`ifdef CHANELS_DISTRIBUTOR_AVERAGE_EN
    return W'($signed(s) >>> ST);
`else
    return s;
`endif
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 2; k++)
      for (int c = 0; c < 4; c++) begin
        m_ac[k][c] = '0;
        m_ph[k][c] = '0;
        m_n[k][c]  = 0;
      end
    exp_q0.delete();
    exp_q1.delete();
  endtask

  task automatic model_apply(input logic v, input logic [AW-1:0] a, input logic [W-1:0] ac,
                             input logic [W-1:0] ph);
    for (int k = 0; k < 2; k++) begin
      int nch = (k == 0) ? 4 : 3;
      if (v && int'(a) < nch) begin
        m_ac[k][a] = m_ac[k][a] + ac;
        m_ph[k][a] = m_ph[k][a] + ph;
        m_n[k][a]  = m_n[k][a] + 1;
        if (m_n[k][a] == N) begin
          if (k == 0) exp_q0.push_back({a, finish_val(m_ac[k][a]), finish_val(m_ph[k][a])});
          else        exp_q1.push_back({a, finish_val(m_ac[k][a]), finish_val(m_ph[k][a])});
          m_ac[k][a] = '0;
          m_ph[k][a] = '0;
          m_n[k][a]  = 0;
        end
      end
    end
  endtask

  task automatic check_inst(input int k, input logic v, input logic [AW-1:0] a,
                            input logic [W-1:0] ac, input logic [W-1:0] ph);
    logic [EW-1:0] got;
    logic [EW-1:0] e;
    got = {a, ac, ph};
    checks++;
    if (rst_q) begin
      if (v !== 1'b0 || got !== '0) begin
        failures++;
        $display("FAIL reset_state inst%0d: vld=%b out=%h required vld=0 out=0", k, v, got);
      end
      last_exp[k] = '0;
    end else if (v === 1'b1) begin
      if ((k == 0 && exp_q0.size() == 0) || (k == 1 && exp_q1.size() == 0)) begin
        failures++;
        $display("FAIL unexpected_vld inst%0d: out=%h, no output expected", k, got);
      end else begin
        e = (k == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
        if (got !== e) begin
          failures++;
          $display("FAIL window_out inst%0d: addr/ac/ph=%h required %h", k, got, e);
        end
        last_exp[k] = e;
      end
    end else if (v !== 1'b0 || got !== last_exp[k]) begin
      failures++;
      $display("FAIL idle_hold inst%0d: vld=%b out=%h required vld=0 out=%h", k, v, got, last_exp[k]);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      check_inst(0, o_vld0, o_addres0, o_ac0, o_ph0);
      check_inst(1, o_vld1, o_addres1, o_ac1, o_ph1);
    end
  end

  // driver tasks
  task automatic send(input logic v, input logic [AW-1:0] a, input logic [W-1:0] ac,
                      input logic [W-1:0] ph);
    i_vld = v;
    i_addres = a;
    i_ac = ac;
    i_ph = ph;
    @(posedge clk);
    #1;
    model_apply(v, a, ac, ph);
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      i_vld = 1'($urandom_range(0, 1));
      i_addres = AW'($urandom_range(0, 3));
      i_ac = $urandom;
      i_ph = $urandom;
      @(posedge clk);
      #1;
    end
    model_clear();
    rst = 1'b0;
    i_vld = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    i_vld = 1'b0;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0) && t < 10) begin
      @(posedge clk);
      t++;
    end
    @(posedge clk);
    #1;
    checks++;
    if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout: pending q0=%0d q1=%0d required 0", exp_q0.size(), exp_q1.size());
      exp_q0.delete();
      exp_q1.delete();
    end
  endtask

  initial begin
    model_clear();
    last_exp[0] = '0;
    last_exp[1] = '0;

    do_reset(3);

    // interleaved rounds: each channel sees ac=2+i, ph=2-i
    for (int i = 0; i < 4; i++)
      for (int c = 0; c < 4; c++)
        send(1'b1, AW'(c), W'(2 + i), W'(2 - i));
    drain();

    // single channel burst
    do_reset(1);
    for (int i = 0; i < 8; i++) send(1'b1, 2'd2, 32'd1, 32'hFFFF_FFFF);
    drain();

    // gaps and addr 3 (ignored by the 3-channel instance)
    do_reset(1);
    for (int i = 0; i < 4; i++) begin
      send(1'b1, 2'd0, W'(10 + i), W'(-3 * i));
      send(1'b0, 2'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
      send(1'b1, 2'd3, 32'd100, 32'd7);
      send(1'b0, 2'd1, 32'h1234_5678, 32'h1);
    end
    drain();

    // wrap-around of the 32-bit sum
    do_reset(1);
    for (int i = 0; i < 4; i++) send(1'b1, 2'd1, 32'h7FFF_FFFF, 32'h8000_0000);
    drain();

    // reset mid-window discards partial sums
    do_reset(1);
    send(1'b1, 2'd1, 32'd9, 32'd9);
    send(1'b1, 2'd1, 32'd9, 32'd9);
    do_reset(1);
    for (int i = 0; i < 4; i++) send(1'b1, 2'd1, 32'd5, 32'd0);
    drain();

    // randomized traffic
    do_reset(2);
    for (int i = 0; i < 400; i++)
      send(1'($urandom_range(0, 3) != 0), AW'($urandom_range(0, 3)), $urandom, $urandom);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
